branch_resolve_unit: RTL and testbench

//  EX-stage consumer of the 32-bit comparator's o_a_lt_b / o_a_eq_b flags. Decodes branch funct3
//  and drives the comparator's unsigned select. Resolves taken/not-taken for B-type, JAL and JALR,

---
 rtl/branch_resolve_unit_if.sv | 44 ++++
 rtl/branch_resolve_unit.sv | 194 +++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_if.sv
// Port bundle for branch_resolve_unit: EX-stage operands and comparator flags in,
// redirect / flush / status / prediction out. The pipeline side uses master.
interface branch_resolve_unit_if #(
    parameter int XLEN = 32
);
    logic            i_valid;
    logic            i_stall;
    logic            i_is_branch;
    logic            i_is_jal;
    logic            i_is_jalr;
    logic [2:0]      i_funct3;
    logic            i_lt;
    logic            i_eq;
    logic [XLEN-1:0] i_pc;
    logic [XLEN-1:0] i_imm;
    logic [XLEN-1:0] i_rs1;
    logic            i_pred_taken;
    logic [XLEN-1:0] i_fetch_pc;

    logic            o_cmp_unsigned;
    logic            o_redirect;
    logic [XLEN-1:0] o_redirect_pc;
    logic [XLEN-1:0] o_link;
    logic            o_flush;
    logic            o_misaligned;
    logic            o_illegal;
    logic            o_fetch_pred;
    logic [31:0]     o_branch_cnt;
    logic [31:0]     o_taken_cnt;

    modport slave (
        input  i_valid, i_stall, i_is_branch, i_is_jal, i_is_jalr, i_funct3,
               i_lt, i_eq, i_pc, i_imm, i_rs1, i_pred_taken, i_fetch_pc,
        output o_cmp_unsigned, o_redirect, o_redirect_pc, o_link, o_flush,
               o_misaligned, o_illegal, o_fetch_pred, o_branch_cnt, o_taken_cnt
    );

    modport master (
        output i_valid, i_stall, i_is_branch, i_is_jal, i_is_jalr, i_funct3,
               i_lt, i_eq, i_pc, i_imm, i_rs1, i_pred_taken, i_fetch_pc,
        input  o_cmp_unsigned, o_redirect, o_redirect_pc, o_link, o_flush,
               o_misaligned, o_illegal, o_fetch_pred, o_branch_cnt, o_taken_cnt
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jump resolution with redirect + flush sequencer towards IF/ID.
// Optional macro BRANCH_PREDICT_EN adds a 2-bit BHT and redirects only on mispredict.
module branch_resolve_unit #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int BHT_ENTRIES  = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_resolve_unit_if.slave bus
);
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_REDIRECT = 2'd1;
    localparam logic [1:0] ST_FLUSH    = 2'd2;

    localparam int            CW         = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
    localparam bit            HAS_FLUSH  = (FLUSH_CYCLES > 1);
    localparam logic [CW-1:0] FLUSH_LOAD = HAS_FLUSH ? CW'(FLUSH_CYCLES - 2) : '0;

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   flush_cnt_q, flush_cnt_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic [XLEN-1:0] link_q, link_d;
    logic            misaligned_q, misaligned_d;
    logic            illegal_q, illegal_d;
    logic [31:0]     branch_cnt_q, branch_cnt_d;
    logic [31:0]     taken_cnt_q, taken_cnt_d;

    logic            sel_jalr, sel_jal, sel_branch, sel_any;
    logic            cond_true, f3_illegal;
    logic            taken, misaligned, redirect_need, accept;
    logic [XLEN-1:0] pc_plus4, jalr_sum, target, redirect_target;

    // jalr > jal > branch when several type flags are raised together
    assign sel_jalr   = bus.i_is_jalr;
    assign sel_jal    = bus.i_is_jal & ~bus.i_is_jalr;
    assign sel_branch = bus.i_is_branch & ~bus.i_is_jal & ~bus.i_is_jalr;
    assign sel_any    = sel_jalr | sel_jal | sel_branch;

    assign bus.o_cmp_unsigned = bus.i_funct3[1];

    always_comb begin
        cond_true  = 1'b0;
        f3_illegal = 1'b0;
        case (bus.i_funct3)
            3'b000:         cond_true  = bus.i_eq;
            3'b001:         cond_true  = ~bus.i_eq;
            3'b100, 3'b110: cond_true  = bus.i_lt;
            3'b101, 3'b111: cond_true  = ~bus.i_lt;
            default:        f3_illegal = 1'b1;
        endcase
    end

    assign pc_plus4   = bus.i_pc + XLEN'(4);
    assign jalr_sum   = bus.i_rs1 + bus.i_imm;
    assign target     = sel_jalr ? (jalr_sum & ~XLEN'(1)) : (bus.i_pc + bus.i_imm);
    assign taken      = sel_jalr | sel_jal | (sel_branch & cond_true & ~f3_illegal);
    assign misaligned = taken & target[1];
    assign accept     = bus.i_valid & ~bus.i_stall & (state_q == ST_IDLE);
    // a predicted-taken branch that resolves not-taken must fall through to pc+4
    assign redirect_target = taken ? target : pc_plus4;

`ifdef BRANCH_PREDICT_EN
    localparam int IW = $clog2(BHT_ENTRIES);

    logic [IW-1:0]          upd_idx, look_idx;
    logic                   bht_upd;
    logic [BHT_ENTRIES-1:0] bht_msb;

    assign upd_idx  = bus.i_pc[IW+1:2];
    assign look_idx = bus.i_fetch_pc[IW+1:2];
    assign bht_upd  = accept & sel_branch;

    generate
        for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
            logic [1:0] ctr_q, ctr_d;

            always_comb begin
                ctr_d = ctr_q;
                if (bht_upd && (upd_idx == IW'(gi))) begin
                    if (taken && (ctr_q != 2'b11))
                        ctr_d = ctr_q + 2'd1;
                    else if (!taken && (ctr_q != 2'b00))
                        ctr_d = ctr_q - 2'd1;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    ctr_q <= 2'b01;
                else
                    ctr_q <= ctr_d;
            end

            assign bht_msb[gi] = ctr_q[1];
        end
    endgenerate

    assign bus.o_fetch_pred = bht_msb[look_idx];
    assign redirect_need    = sel_any & ~misaligned & (taken != bus.i_pred_taken);

    logic unused_fetch_bits;
    assign unused_fetch_bits = ^{bus.i_fetch_pc[XLEN-1:IW+2], bus.i_fetch_pc[1:0]};
`else
    assign bus.o_fetch_pred = 1'b0;
    assign redirect_need    = taken & ~misaligned;

    logic unused_pred_inputs;
    assign unused_pred_inputs = ^{bus.i_pred_taken, bus.i_fetch_pc, BHT_ENTRIES[0]};
`endif

    // Sequencer: a stall freezes the state and the flush countdown wherever it is.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        if (!bus.i_stall) begin
            case (state_q)
                ST_IDLE: begin
                    if (accept && redirect_need)
                        state_d = ST_REDIRECT;
                end
                ST_REDIRECT: begin
                    if (HAS_FLUSH) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FLUSH_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_q == '0)
                        state_d = ST_IDLE;
                    else
                        flush_cnt_d = flush_cnt_q - CW'(1);
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        redirect_pc_d = redirect_pc_q;
        link_d        = link_q;
        misaligned_d  = misaligned_q;
        illegal_d     = illegal_q;
        branch_cnt_d  = branch_cnt_q;
        taken_cnt_d   = taken_cnt_q;
        if (!bus.i_stall) begin
            misaligned_d = accept & misaligned;
            illegal_d    = accept & sel_branch & f3_illegal;
        end
        if (accept && redirect_need)
            redirect_pc_d = redirect_target;
        if (accept && (sel_jal || sel_jalr))
            link_d = pc_plus4;
        if (accept && sel_branch && !f3_illegal) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
            if (taken)
                taken_cnt_d = taken_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            flush_cnt_q   <= '0;
            redirect_pc_q <= '0;
            link_q        <= '0;
            misaligned_q  <= 1'b0;
            illegal_q     <= 1'b0;
            branch_cnt_q  <= '0;
            taken_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            redirect_pc_q <= redirect_pc_d;
            link_q        <= link_d;
            misaligned_q  <= misaligned_d;
            illegal_q     <= illegal_d;
            branch_cnt_q  <= branch_cnt_d;
            taken_cnt_q   <= taken_cnt_d;
        end
    end

    // Decoded straight from the state register so reset drops them without a clock.
    assign bus.o_redirect    = (state_q == ST_REDIRECT);
    assign bus.o_flush       = (state_q != ST_IDLE);
    assign bus.o_redirect_pc = redirect_pc_q;
    assign bus.o_link        = link_q;
    assign bus.o_misaligned  = misaligned_q;
    assign bus.o_illegal     = illegal_q;
    assign bus.o_branch_cnt  = branch_cnt_q;
    assign bus.o_taken_cnt   = taken_cnt_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: expected results queued at issue, compared
// the cycle after accept; plus directed stall, async-reset and wrong-path checks.
module tb_branch_resolve_unit;
    localparam int FC = 2;

    typedef struct {
        string       name;
        logic        redirect;
        logic [31:0] rpc;
        logic        mis;
        logic        ill;
        logic [31:0] link;
        logic [31:0] bcnt;
        logic [31:0] tcnt;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    exp_t sb[$];

    logic [31:0] m_rpc, m_link, m_bcnt, m_tcnt;

    branch_resolve_unit_if #(.XLEN(32)) bus_if ();

    branch_resolve_unit #(
        .XLEN(32),
        .FLUSH_CYCLES(FC),
        .BHT_ENTRIES(64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        bus_if.i_valid      = 1'b0;
        bus_if.i_stall      = 1'b0;
        bus_if.i_is_branch  = 1'b0;
        bus_if.i_is_jal     = 1'b0;
        bus_if.i_is_jalr    = 1'b0;
        bus_if.i_funct3     = 3'b000;
        bus_if.i_lt         = 1'b0;
        bus_if.i_eq         = 1'b0;
        bus_if.i_pc         = 32'h0;
        bus_if.i_imm        = 32'h0;
        bus_if.i_rs1        = 32'h0;
        bus_if.i_pred_taken = 1'b0;
    endtask

    task automatic model_reset();
        m_rpc  = 32'h0;
        m_link = 32'h0;
        m_bcnt = 32'h0;
        m_tcnt = 32'h0;
    endtask

    // Drive one instruction at the current (post-edge) point, queue the expectation,
    // then compare after the capturing edge and walk the flush window with wrong-path traffic.
    task automatic send(input string name, input logic jr, input logic j, input logic b,
                        input logic [2:0] f3, input logic lt, input logic eq,
                        input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                        input logic pred);
        exp_t        e, got_e;
        logic        cond, ill, take, mis, redir, is_b;
        logic [31:0] tgt;
        cond = 1'b0;
        ill  = 1'b0;
        case (f3)
            3'b000: cond = eq;
            3'b001: cond = !eq;
            3'b100: cond = lt;
            3'b110: cond = lt;
            3'b101: cond = !lt;
            3'b111: cond = !lt;
            default: ill = 1'b1;
        endcase
        is_b = b && !j && !jr;
        ill  = ill && is_b;
        tgt  = jr ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
        take = jr || j || (is_b && cond && !ill);
        mis  = take && tgt[1];
`ifdef BRANCH_PREDICT_EN
        redir = (jr || j || b) && !mis && (take != pred);
`else
        redir = take && !mis;
`endif
        if (redir) m_rpc = take ? tgt : (pc + 32'd4);
        if (jr || j) m_link = pc + 32'd4;
        if (is_b && !ill) begin
            m_bcnt = m_bcnt + 32'd1;
            if (take) m_tcnt = m_tcnt + 32'd1;
        end
        e.name = name; e.redirect = redir; e.rpc = m_rpc; e.mis = mis; e.ill = ill;
        e.link = m_link; e.bcnt = m_bcnt; e.tcnt = m_tcnt;
        sb.push_back(e);

        bus_if.i_valid = 1'b1; bus_if.i_is_jalr = jr; bus_if.i_is_jal = j;
        bus_if.i_is_branch = b; bus_if.i_funct3 = f3; bus_if.i_lt = lt; bus_if.i_eq = eq;
        bus_if.i_pc = pc; bus_if.i_imm = imm; bus_if.i_rs1 = rs1; bus_if.i_pred_taken = pred;
        #1;
        check({name, ".cmp_unsigned"}, 32'(bus_if.o_cmp_unsigned), 32'(f3[1]));
        @(posedge clk); #1;
        clear_inputs();
        got_e = sb.pop_front();
        check({got_e.name, ".redirect"}, 32'(bus_if.o_redirect), 32'(got_e.redirect));
        check({got_e.name, ".flush"}, 32'(bus_if.o_flush), 32'(got_e.redirect));
        check({got_e.name, ".redirect_pc"}, bus_if.o_redirect_pc, got_e.rpc);
        check({got_e.name, ".misaligned"}, 32'(bus_if.o_misaligned), 32'(got_e.mis));
        check({got_e.name, ".illegal"}, 32'(bus_if.o_illegal), 32'(got_e.ill));
        check({got_e.name, ".link"}, bus_if.o_link, got_e.link);
        check({got_e.name, ".branch_cnt"}, bus_if.o_branch_cnt, got_e.bcnt);
        check({got_e.name, ".taken_cnt"}, bus_if.o_taken_cnt, got_e.tcnt);
        $display("txn %s: redirect=%0b pc=%h mis=%0b ill=%0b link=%h bcnt=%0d tcnt=%0d",
                 got_e.name, bus_if.o_redirect, bus_if.o_redirect_pc, bus_if.o_misaligned,
                 bus_if.o_illegal, bus_if.o_link, bus_if.o_branch_cnt, bus_if.o_taken_cnt);
        if (got_e.redirect) begin
            // wrong-path taken BEQ presented throughout the flush must be ignored
            bus_if.i_valid = 1'b1; bus_if.i_is_branch = 1'b1; bus_if.i_eq = 1'b1;
            bus_if.i_pc = 32'h0000_0800; bus_if.i_imm = 32'h0000_0040;
            for (int k = 1; k < FC; k++) begin
                @(posedge clk); #1;
                check({got_e.name, ".flush_hold"}, 32'(bus_if.o_flush), 32'd1);
                check({got_e.name, ".redirect_drop"}, 32'(bus_if.o_redirect), 32'd0);
            end
            @(posedge clk); #1;
            clear_inputs();
            check({got_e.name, ".flush_end"}, 32'(bus_if.o_flush), 32'd0);
            check({got_e.name, ".wrongpath_cnt"}, bus_if.o_branch_cnt, m_bcnt);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        clear_inputs();
        bus_if.i_fetch_pc = 32'h0;
        model_reset();

        #12;
        check("rst.redirect", 32'(bus_if.o_redirect), 32'd0);
        check("rst.flush", 32'(bus_if.o_flush), 32'd0);
        check("rst.redirect_pc", bus_if.o_redirect_pc, 32'h0);
        check("rst.link", bus_if.o_link, 32'h0);
        check("rst.branch_cnt", bus_if.o_branch_cnt, 32'h0);
        check("rst.taken_cnt", bus_if.o_taken_cnt, 32'h0);
        check("rst.misaligned", 32'(bus_if.o_misaligned), 32'd0);
        check("rst.illegal", 32'(bus_if.o_illegal), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

`ifdef BRANCH_PREDICT_EN
        bus_if.i_fetch_pc = 32'h0000_0040;
        #1;
        check("bht.pred0", 32'(bus_if.o_fetch_pred), 32'd0);
        send("bht_beq1", 0, 0, 1, 3'b000, 0, 1, 32'h40, 32'h20, 32'h0, 1'b0);
        check("bht.pred1", 32'(bus_if.o_fetch_pred), 32'd1);
        send("bht_beq2", 0, 0, 1, 3'b000, 0, 1, 32'h40, 32'h20, 32'h0, 1'b1);
        check("bht.pred2", 32'(bus_if.o_fetch_pred), 32'd1);
        send("bht_beq3", 0, 0, 1, 3'b000, 0, 1, 32'h40, 32'h20, 32'h0, 1'b1);
        check("bht.pred3", 32'(bus_if.o_fetch_pred), 32'd1);
`else
        bus_if.i_fetch_pc = 32'h0000_0040;
        #1;
        check("nopred.fetch_pred", 32'(bus_if.o_fetch_pred), 32'd0);
`endif

        send("beq_taken",   0, 0, 1, 3'b000, 0, 1, 32'h0000_0100, 32'h0000_0020, 32'h0, 1'b0);
        send("bltu_nt",     0, 0, 1, 3'b110, 0, 0, 32'h0000_0104, 32'h0000_0040, 32'h0, 1'b0);
        send("bne_taken",   0, 0, 1, 3'b001, 1, 0, 32'h0000_0108, 32'h0000_0010, 32'h0, 1'b0);
        send("blt_back",    0, 0, 1, 3'b100, 1, 0, 32'h0000_0200, 32'hFFFF_FFF8, 32'h0, 1'b0);
        send("bge_nt",      0, 0, 1, 3'b101, 1, 0, 32'h0000_0204, 32'h0000_0010, 32'h0, 1'b0);
        send("bgeu_taken",  0, 0, 1, 3'b111, 0, 1, 32'h0000_0208, 32'h0000_0030, 32'h0, 1'b0);
        send("bne_nt",      0, 0, 1, 3'b001, 0, 1, 32'h0000_020C, 32'h0000_0030, 32'h0, 1'b0);
        send("illegal_010", 0, 0, 1, 3'b010, 1, 1, 32'h0000_0210, 32'h0000_0010, 32'h0, 1'b0);
        send("illegal_011", 0, 0, 1, 3'b011, 0, 0, 32'h0000_0214, 32'h0000_0010, 32'h0, 1'b0);
        send("jalr_misal",  1, 0, 0, 3'b000, 0, 0, 32'h0000_0300, 32'h0000_0000, 32'h0000_1003, 1'b0);
        send("jal",         0, 1, 0, 3'b000, 0, 0, 32'h0000_0400, 32'h0000_0040, 32'h0, 1'b0);
        send("jalr_ok",     1, 0, 0, 3'b000, 0, 0, 32'h0000_0410, 32'h0000_0010, 32'h0000_2001, 1'b0);
        send("br_misal",    0, 0, 1, 3'b000, 0, 1, 32'h0000_0420, 32'h0000_0002, 32'h0, 1'b0);
        send("wrap",        0, 0, 1, 3'b000, 0, 1, 32'hFFFF_FFF0, 32'h0000_0020, 32'h0, 1'b0);
        send("prio_all",    1, 1, 1, 3'b010, 0, 0, 32'h0000_0500, 32'h0000_0100, 32'h0000_3000, 1'b0);
        send("prio_jal_br", 0, 1, 1, 3'b000, 0, 0, 32'h0000_0600, 32'h0000_0080, 32'h0, 1'b0);
        send("non_ctrl",    0, 0, 0, 3'b000, 0, 1, 32'h0000_0700, 32'h0000_0080, 32'h0, 1'b0);

        // stall in REDIRECT keeps the pulse up; stall in FLUSH stretches the flush
        bus_if.i_valid = 1'b1; bus_if.i_is_branch = 1'b1; bus_if.i_eq = 1'b1;
        bus_if.i_pc = 32'h0000_0900; bus_if.i_imm = 32'h0000_0010;
        m_bcnt = m_bcnt + 32'd1; m_tcnt = m_tcnt + 32'd1; m_rpc = 32'h0000_0910;
        @(posedge clk); #1;
        clear_inputs();
        check("stall.redirect", 32'(bus_if.o_redirect), 32'd1);
        check("stall.redirect_pc", bus_if.o_redirect_pc, m_rpc);
        bus_if.i_stall = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            check("stall.redirect_held", 32'(bus_if.o_redirect), 32'd1);
        end
        bus_if.i_stall = 1'b0;
        @(posedge clk); #1;
        check("stall.in_flush", 32'(bus_if.o_flush), 32'd1);
        check("stall.redirect_gone", 32'(bus_if.o_redirect), 32'd0);
        bus_if.i_stall = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("stall.flush_held", 32'(bus_if.o_flush), 32'd1);
        end
        bus_if.i_stall = 1'b0;
        @(posedge clk); #1;
        check("stall.flush_end", 32'(bus_if.o_flush), 32'd0);
        check("stall.branch_cnt", bus_if.o_branch_cnt, m_bcnt);
        $display("txn stall_seq: flush released, bcnt=%0d", bus_if.o_branch_cnt);

        // asynchronous reset in the middle of the flush window
        bus_if.i_valid = 1'b1; bus_if.i_is_branch = 1'b1; bus_if.i_eq = 1'b1;
        bus_if.i_pc = 32'h0000_0A00; bus_if.i_imm = 32'h0000_0020;
        @(posedge clk); #1;
        clear_inputs();
        @(posedge clk); #1;
        check("rstmid.flush_before", 32'(bus_if.o_flush), 32'd1);
        rst = 1'b1;
        #1;
        check("rstmid.flush", 32'(bus_if.o_flush), 32'd0);
        check("rstmid.redirect", 32'(bus_if.o_redirect), 32'd0);
        check("rstmid.redirect_pc", bus_if.o_redirect_pc, 32'h0);
        check("rstmid.branch_cnt", bus_if.o_branch_cnt, 32'h0);
        $display("txn rst_mid_flush: flush=%0b bcnt=%0d", bus_if.o_flush, bus_if.o_branch_cnt);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 24; i++) begin
            logic [2:0]  rf3;
            logic [31:0] rpc, rimm;
            rf3  = 3'($urandom_range(0, 7));
            rpc  = $urandom() & 32'hFFFF_FFFC;
            rimm = $urandom_range(0, 1) ? ($urandom() & 32'h0000_0FFE) : ($urandom() | 32'hFFFF_F000);
            rimm = rimm & 32'hFFFF_FFFE;
            send($sformatf("rnd%0d", i), 0, 0, 1, rf3, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), rpc, rimm, 32'h0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
